decode_stage: RTL and testbench

Pipeline ID stage of the 32-bit MIPS core: the IF/ID pipeline register, the 32×32 register file with WB write-through, the early branch comparator with hazard-unit-driven forwarding, and branch/jump target generation. It sits directly upstream of the hazard unit. It produces `RsD`/`RtD` and consumes `StallD`/`ForwardAD`/`ForwardBD`. It drives the PC-select logic and the ID/EX register.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/decode_stage_if.sv | 47 ++++
 rtl/register_file.sv | 43 ++++
 rtl/decode_stage.sv | 77 +++++++
 tb/tb_decode_stage.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: widths, instruction field positions, opcodes.
package mips_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_COUNT      = 32;

  // Instruction field bit positions (R/I/J formats)
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int TGT_MSB = 25;

  typedef logic [DATA_WIDTH-1:0]     word_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  localparam word_t      NOP_INSTR = 32'h0000_0000;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_J      = 6'h02;

endpackage

// File: rtl/decode_stage_if.sv
// Signal bundle between the decode stage and its neighbours (fetch, hazard
// unit, control unit, MEM/WB feedback, PC select and ID/EX).
interface decode_stage_if;
  import mips_pkg::*;

  // fetch / hazard / control / feedback inputs to decode
  word_t     InstrF;
  word_t     PCPlus4F;
  logic      StallD;
  logic      ForwardAD;
  logic      ForwardBD;
  word_t     ALUOutM;
  logic      BranchD;
  logic      JumpD;
  logic      RegWriteW;
  reg_addr_t WriteRegW;
  word_t     ResultW;

  // decode outputs
  word_t     InstrD;
  word_t     PCPlus4D;
  reg_addr_t RsD;
  reg_addr_t RtD;
  reg_addr_t RdD;
  word_t     SignImmD;
  word_t     RD1D;
  word_t     RD2D;
  word_t     PCBranchD;
  word_t     PCJumpD;
  logic      PCSrcD;
  logic      RedirectD;

  modport slave (
    input  InstrF, PCPlus4F, StallD, ForwardAD, ForwardBD, ALUOutM,
           BranchD, JumpD, RegWriteW, WriteRegW, ResultW,
    output InstrD, PCPlus4D, RsD, RtD, RdD, SignImmD, RD1D, RD2D,
           PCBranchD, PCJumpD, PCSrcD, RedirectD
  );

  modport master (
    output InstrF, PCPlus4F, StallD, ForwardAD, ForwardBD, ALUOutM,
           BranchD, JumpD, RegWriteW, WriteRegW, ResultW,
    input  InstrD, PCPlus4D, RsD, RtD, RdD, SignImmD, RD1D, RD2D,
           PCBranchD, PCJumpD, PCSrcD, RedirectD
  );

endinterface

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports with WB write-through,
// one synchronous write port, synchronous clear. Register 0 is hardwired 0.
module register_file
  import mips_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  reg_addr_t i_ra1,
  input  reg_addr_t i_ra2,
  input  logic      i_we,
  input  reg_addr_t i_wa,
  input  word_t     i_wd,
  output word_t     o_rd1,
  output word_t     o_rd2
);

  word_t r_regs [REG_COUNT];
  logic  w_wr_en;

  assign w_wr_en = i_we && (i_wa != '0);

  // Write port and synchronous clear of the whole array.
  // NOTE: the array is cleared on reset because software may read registers
  // before writing them; non-blocking assignments keep the read ports seeing
  // the pre-edge contents within the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // Read ports: register 0 reads 0, a same-cycle WB write is bypassed.
  // NOTE: both outputs get a default first so no path leaves them unassigned.
  always_comb begin
    o_rd1 = '0;
    o_rd2 = '0;
    if (i_ra1 != '0) o_rd1 = (w_wr_en && i_wa == i_ra1) ? i_wd : r_regs[i_ra1];
    if (i_ra2 != '0) o_rd2 = (w_wr_en && i_wa == i_ra2) ? i_wd : r_regs[i_ra2];
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: IF/ID register, register file, early branch comparator with
// forwarding, and branch/jump target generation.
module decode_stage
  import mips_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  decode_stage_if.slave       bus
);

  word_t     r_instr;
  word_t     r_pcplus4;
  word_t     w_rd1;
  word_t     w_rd2;
  word_t     w_sign_imm;
  word_t     w_cmp_a;
  word_t     w_cmp_b;
  logic      w_equal;
  logic      w_pcsrc;
  logic      w_redirect;
  reg_addr_t w_rs;
  reg_addr_t w_rt;

  // IF/ID register: reset, then stall-hold, then bubble on redirect, else load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_instr   <= NOP_INSTR;
      r_pcplus4 <= '0;
    end else if (!bus.StallD) begin
      if (w_redirect) begin
        r_instr   <= NOP_INSTR;
        r_pcplus4 <= '0;
      end else begin
        r_instr   <= bus.InstrF;
        r_pcplus4 <= bus.PCPlus4F;
      end
    end
  end

  assign w_rs       = r_instr[RS_MSB:RS_LSB];
  assign w_rt       = r_instr[RT_MSB:RT_LSB];
  assign w_sign_imm = {{(DATA_WIDTH-16){r_instr[IMM_MSB]}}, r_instr[IMM_MSB:0]};

  register_file u_register_file (
    .CLK   (CLK),
    .RST   (RST),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .i_we  (bus.RegWriteW),
    .i_wa  (bus.WriteRegW),
    .i_wd  (bus.ResultW),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  // Early branch compare; a MEM forward overrides the (possibly bypassed) read.
  // A stalled branch sees stale operands, so its taken decision is masked.
  assign w_cmp_a    = bus.ForwardAD ? bus.ALUOutM : w_rd1;
  assign w_cmp_b    = bus.ForwardBD ? bus.ALUOutM : w_rd2;
  assign w_equal    = (w_cmp_a == w_cmp_b);
  assign w_pcsrc    = bus.BranchD && w_equal && !bus.StallD;
  assign w_redirect = w_pcsrc || (bus.JumpD && !bus.StallD);

  assign bus.InstrD    = r_instr;
  assign bus.PCPlus4D  = r_pcplus4;
  assign bus.RsD       = w_rs;
  assign bus.RtD       = w_rt;
  assign bus.RdD       = r_instr[RD_MSB:RD_LSB];
  assign bus.SignImmD  = w_sign_imm;
  assign bus.RD1D      = w_rd1;
  assign bus.RD2D      = w_rd2;
  assign bus.PCBranchD = r_pcplus4 + {w_sign_imm[DATA_WIDTH-3:0], 2'b00};
  assign bus.PCJumpD   = {r_pcplus4[DATA_WIDTH-1:DATA_WIDTH-4], r_instr[TGT_MSB:0], 2'b00};
  assign bus.PCSrcD    = w_pcsrc;
  assign bus.RedirectD = w_redirect;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic compared against an architectural model of the ID stage.
module tb_decode_stage;
  import mips_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  decode_stage_if dif();

  decode_stage u_dut (.CLK(CLK), .RST(RST), .bus(dif));

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Architectural model state
  logic [31:0] m_regs [32];
  logic [31:0] m_instr;
  logic [31:0] m_pc;

  function automatic logic [31:0] exp_rd(logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (dif.RegWriteW && dif.WriteRegW == a) return dif.ResultW;
    return m_regs[a];
  endfunction

  function automatic logic [4:0] f_rs(); return 5'((m_instr >> 21) & 32'h1F); endfunction
  function automatic logic [4:0] f_rt(); return 5'((m_instr >> 16) & 32'h1F); endfunction
  function automatic logic [4:0] f_rd(); return 5'((m_instr >> 11) & 32'h1F); endfunction

  function automatic logic [31:0] exp_sext();
    return 32'($signed(m_instr[15:0]));
  endfunction

  function automatic logic [31:0] exp_branch();
    return m_pc + exp_sext() * 32'd4;
  endfunction

  function automatic logic [31:0] exp_jump();
    return (m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 32'd4);
  endfunction

  function automatic logic exp_pcsrc();
    logic [31:0] a, b;
    a = dif.ForwardAD ? dif.ALUOutM : exp_rd(f_rs());
    b = dif.ForwardBD ? dif.ALUOutM : exp_rd(f_rt());
    return dif.BranchD && (a == b) && !dif.StallD;
  endfunction

  function automatic logic exp_redirect();
    return exp_pcsrc() || (dif.JumpD && !dif.StallD);
  endfunction

  // Advance one clock edge, updating the model from the pre-edge inputs.
  task automatic cycle();
    logic red, st, rst_v, we;
    logic [4:0] wa;
    logic [31:0] wd, i_f, p_f;
    red = exp_redirect(); st = dif.StallD; rst_v = RST; we = dif.RegWriteW;
    wa = dif.WriteRegW; wd = dif.ResultW; i_f = dif.InstrF; p_f = dif.PCPlus4F;
    @(posedge CLK);
    if (rst_v) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_instr = 32'd0; m_pc = 32'd0;
    end else begin
      if (we && wa != 5'd0) m_regs[wa] = wd;
      if (!st) begin
        if (red) begin m_instr = 32'd0; m_pc = 32'd0; end
        else begin m_instr = i_f; m_pc = p_f; end
      end
    end
    #1;
  endtask

  task automatic idle();
    RST = 1'b0;
    dif.InstrF = '0; dif.PCPlus4F = '0; dif.StallD = 1'b0;
    dif.ForwardAD = 1'b0; dif.ForwardBD = 1'b0; dif.ALUOutM = '0;
    dif.BranchD = 1'b0; dif.JumpD = 1'b0;
    dif.RegWriteW = 1'b0; dif.WriteRegW = '0; dif.ResultW = '0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    dif.RegWriteW = 1'b1; dif.WriteRegW = a; dif.ResultW = d;
    cycle();
    dif.RegWriteW = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    for (int i = 1; i < 8; i++) wb_write(5'(i), $urandom);
    // load something non-zero, then reset during a stall with a WB write pending
    dif.InstrF = $urandom; dif.PCPlus4F = $urandom; cycle();
    RST = 1'b1; dif.StallD = 1'b1; dif.RegWriteW = 1'b1; dif.WriteRegW = 5'd3;
    dif.ResultW = $urandom; dif.InstrF = $urandom; dif.PCPlus4F = $urandom;
    dif.ForwardAD = 1'b1; dif.ALUOutM = $urandom;
    cycle();
    idle(); #1;
    checks++; if (dif.InstrD !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h want 0", dif.InstrD); end
    checks++; if (dif.PCPlus4D !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", dif.PCPlus4D); end
    checks++; if ({dif.RsD, dif.RtD, dif.RdD, dif.SignImmD} !== 47'd0) begin errors++;
      $display("FAIL reset_fields: rs=%0d rt=%0d rd=%0d imm=%h want 0", dif.RsD, dif.RtD, dif.RdD, dif.SignImmD); end
    checks++; if ({dif.RD1D, dif.RD2D, dif.PCBranchD, dif.PCJumpD} !== 128'd0) begin errors++;
      $display("FAIL reset_data: rd1=%h rd2=%h br=%h j=%h want 0", dif.RD1D, dif.RD2D, dif.PCBranchD, dif.PCJumpD); end
    checks++; if ({dif.PCSrcD, dif.RedirectD} !== 2'b00) begin errors++;
      $display("FAIL reset_ctrl: pcsrc=%b redirect=%b want 0", dif.PCSrcD, dif.RedirectD); end
    // every register must read back 0 after the clear
    for (int r = 0; r < 32; r++) begin
      dif.InstrF = {6'h00, 5'(r), 5'(31 - r), 16'h0000};
      cycle();
      checks++; if (dif.RD1D !== 32'd0 || dif.RD2D !== 32'd0) begin errors++;
        $display("FAIL reset_regs r%0d: rd1=%h rd2=%h want 0", r, dif.RD1D, dif.RD2D); end
    end
  endtask

  task automatic test_writethrough();
    idle();
    dif.InstrF = {6'h00, 5'd5, 5'd0, 16'h0000}; cycle();
    dif.RegWriteW = 1'b1; dif.WriteRegW = 5'd5; dif.ResultW = 32'hDEADBEEF; #1;
    checks++; if (dif.RD1D !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_bypass: got %h want deadbeef", dif.RD1D); end
    cycle(); dif.RegWriteW = 1'b0; #1;
    checks++; if (dif.RD1D !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_array: got %h want deadbeef", dif.RD1D); end
    dif.InstrF = 32'h0; cycle();
    dif.RegWriteW = 1'b1; dif.WriteRegW = 5'd0; dif.ResultW = 32'hFFFF_FFFF; #1;
    checks++; if (dif.RD1D !== 32'd0) begin errors++; $display("FAIL wb_r0_bypass: got %h want 0", dif.RD1D); end
    cycle(); dif.RegWriteW = 1'b0; #1;
    checks++; if (dif.RD1D !== 32'd0) begin errors++; $display("FAIL wb_r0_array: got %h want 0", dif.RD1D); end
  endtask

  task automatic test_stall();
    logic [31:0] ia, pa;
    idle();
    ia = {6'h00, 26'($urandom)}; pa = $urandom;
    dif.InstrF = ia; dif.PCPlus4F = pa; cycle();
    checks++; if (dif.InstrD !== ia) begin errors++; $display("FAIL stall_load: got %h want %h", dif.InstrD, ia); end
    dif.StallD = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dif.InstrF = $urandom; dif.PCPlus4F = $urandom; cycle();
      checks++; if (dif.InstrD !== ia || dif.PCPlus4D !== pa) begin errors++;
        $display("FAIL stall_hold %0d: instr=%h pc=%h want %h %h", k, dif.InstrD, dif.PCPlus4D, ia, pa); end
    end
    dif.StallD = 1'b0; dif.InstrF = 32'h1234_5678; dif.PCPlus4F = 32'h0000_0A00; cycle();
    checks++; if (dif.InstrD !== 32'h1234_5678 || dif.PCPlus4D !== 32'h0000_0A00) begin errors++;
      $display("FAIL stall_release: instr=%h pc=%h want 12345678 00000a00", dif.InstrD, dif.PCPlus4D); end
  endtask

  task automatic test_branch();
    logic [31:0] beq;
    idle();
    beq = {OP_BEQ, 5'd7, 5'd7, 16'hFFFF};
    dif.InstrF = beq; dif.PCPlus4F = 32'h100; cycle();
    dif.InstrF = $urandom; dif.PCPlus4F = $urandom; dif.BranchD = 1'b1; #1;
    checks++; if (dif.PCSrcD !== 1'b1 || dif.RedirectD !== 1'b1) begin errors++;
      $display("FAIL br_taken: pcsrc=%b redirect=%b want 1 1", dif.PCSrcD, dif.RedirectD); end
    checks++; if (dif.PCBranchD !== 32'h0000_00FC) begin errors++; $display("FAIL br_target: got %h want 000000fc", dif.PCBranchD); end
    cycle(); dif.BranchD = 1'b0; #1;
    checks++; if (dif.InstrD !== 32'd0 || dif.PCPlus4D !== 32'd0) begin errors++;
      $display("FAIL br_flush: instr=%h pc=%h want 0 0", dif.InstrD, dif.PCPlus4D); end
    // same branch while stalled: no redirect, no clear, re-evaluated on release
    dif.InstrF = beq; dif.PCPlus4F = 32'h100; cycle();
    dif.InstrF = $urandom; dif.BranchD = 1'b1; dif.StallD = 1'b1; #1;
    checks++; if (dif.PCSrcD !== 1'b0 || dif.RedirectD !== 1'b0) begin errors++;
      $display("FAIL br_stall: pcsrc=%b redirect=%b want 0 0", dif.PCSrcD, dif.RedirectD); end
    cycle();
    checks++; if (dif.InstrD !== beq) begin errors++; $display("FAIL br_stall_hold: got %h want %h", dif.InstrD, beq); end
    dif.StallD = 1'b0; #1;
    checks++; if (dif.PCSrcD !== 1'b1) begin errors++; $display("FAIL br_release: pcsrc=%b want 1", dif.PCSrcD); end
    cycle(); dif.BranchD = 1'b0; #1;
    checks++; if (dif.InstrD !== 32'd0) begin errors++; $display("FAIL br_release_flush: got %h want 0", dif.InstrD); end
  endtask

  task automatic test_forward();
    idle();
    wb_write(5'd1, 32'd3);
    wb_write(5'd2, 32'd7);
    dif.InstrF = {OP_BEQ, 5'd1, 5'd2, 16'h0010}; cycle();
    dif.BranchD = 1'b1; dif.ForwardAD = 1'b1; dif.ALUOutM = 32'd7; #1;
    checks++; if (dif.RD1D !== 32'd3 || dif.RD2D !== 32'd7) begin errors++;
      $display("FAIL fwd_reads: rd1=%h rd2=%h want 3 7", dif.RD1D, dif.RD2D); end
    checks++; if (dif.PCSrcD !== 1'b1) begin errors++; $display("FAIL fwd_a_on: pcsrc=%b want 1", dif.PCSrcD); end
    dif.ForwardAD = 1'b0; #1;
    checks++; if (dif.PCSrcD !== 1'b0 || dif.RedirectD !== 1'b0) begin errors++;
      $display("FAIL fwd_a_off: pcsrc=%b redirect=%b want 0 0", dif.PCSrcD, dif.RedirectD); end
    dif.ForwardBD = 1'b1; dif.ALUOutM = 32'd3; #1;
    checks++; if (dif.PCSrcD !== 1'b1) begin errors++; $display("FAIL fwd_b_on: pcsrc=%b want 1", dif.PCSrcD); end
    // WB bypass makes rs equal 7; a MEM forward of 9 must still win
    dif.ForwardBD = 1'b0; dif.RegWriteW = 1'b1; dif.WriteRegW = 5'd1; dif.ResultW = 32'd7; #1;
    checks++; if (dif.RD1D !== 32'd7 || dif.PCSrcD !== 1'b1) begin errors++;
      $display("FAIL fwd_wb_bypass: rd1=%h pcsrc=%b want 7 1", dif.RD1D, dif.PCSrcD); end
    dif.ForwardAD = 1'b1; dif.ALUOutM = 32'd9; #1;
    checks++; if (dif.PCSrcD !== 1'b0) begin errors++; $display("FAIL fwd_precedence: pcsrc=%b want 0", dif.PCSrcD); end
    dif.BranchD = 1'b0; dif.ForwardAD = 1'b0; cycle();
    idle();
  endtask

  task automatic test_jump();
    idle();
    dif.InstrF = 32'h0800_0040; dif.PCPlus4F = 32'h0040_0004; cycle();
    dif.JumpD = 1'b1; dif.InstrF = $urandom; #1;
    checks++; if (dif.PCJumpD !== 32'h0000_0100) begin errors++; $display("FAIL jump_target: got %h want 00000100", dif.PCJumpD); end
    checks++; if (dif.RedirectD !== 1'b1 || dif.PCSrcD !== 1'b0) begin errors++;
      $display("FAIL jump_redirect: redirect=%b pcsrc=%b want 1 0", dif.RedirectD, dif.PCSrcD); end
    cycle(); dif.JumpD = 1'b0; #1;
    checks++; if (dif.InstrD !== 32'd0) begin errors++; $display("FAIL jump_flush: got %h want 0", dif.InstrD); end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int n = 0; n < 400; n++) begin
      RST = ($urandom_range(0, 39) == 0);
      dif.StallD    = ($urandom_range(0, 3) == 0);
      dif.BranchD   = ($urandom_range(0, 2) == 0);
      dif.JumpD     = ($urandom_range(0, 5) == 0);
      dif.ForwardAD = ($urandom_range(0, 3) == 0);
      dif.ForwardBD = ($urandom_range(0, 3) == 0);
      dif.ALUOutM   = $urandom_range(0, 3);
      dif.RegWriteW = $urandom_range(0, 1) == 1;
      dif.WriteRegW = 5'($urandom_range(0, 7));
      dif.ResultW   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      dif.InstrF = ins; dif.PCPlus4F = $urandom;
      #1;
      checks++; if (dif.InstrD !== m_instr || dif.PCPlus4D !== m_pc) begin errors++;
        $display("FAIL rnd_ifid %0d: instr=%h pc=%h want %h %h", n, dif.InstrD, dif.PCPlus4D, m_instr, m_pc); end
      checks++; if ({dif.RsD, dif.RtD, dif.RdD} !== {f_rs(), f_rt(), f_rd()} || dif.SignImmD !== exp_sext()) begin errors++;
        $display("FAIL rnd_fields %0d: rs=%0d rt=%0d rd=%0d imm=%h want %0d %0d %0d %h", n,
                 dif.RsD, dif.RtD, dif.RdD, dif.SignImmD, f_rs(), f_rt(), f_rd(), exp_sext()); end
      checks++; if (dif.RD1D !== exp_rd(f_rs()) || dif.RD2D !== exp_rd(f_rt())) begin errors++;
        $display("FAIL rnd_reads %0d: rd1=%h rd2=%h want %h %h", n, dif.RD1D, dif.RD2D, exp_rd(f_rs()), exp_rd(f_rt())); end
      checks++; if (dif.PCBranchD !== exp_branch() || dif.PCJumpD !== exp_jump()) begin errors++;
        $display("FAIL rnd_targets %0d: br=%h j=%h want %h %h", n, dif.PCBranchD, dif.PCJumpD, exp_branch(), exp_jump()); end
      checks++; if (dif.PCSrcD !== exp_pcsrc() || dif.RedirectD !== exp_redirect()) begin errors++;
        $display("FAIL rnd_ctrl %0d: pcsrc=%b redirect=%b want %b %b", n, dif.PCSrcD, dif.RedirectD, exp_pcsrc(), exp_redirect()); end
      cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    RST = 1'b1;
    #1;
    cycle();
    RST = 1'b0;
    test_reset();
    test_writethrough();
    test_stall();
    test_branch();
    test_forward();
    test_jump();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
